// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter in front of mux4_1.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // First set bit of req scanning circularly from ptr; returns ptr when req is empty,
  // so callers must qualify the result with |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// Single-bit 4:1 mux datapath; select is {s1,s0}.
module mux4_1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  always_comb begin
    y = i0;
    case ({s1, s0})
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the mux4_1 select lines; bounds each ownership to MAX_HOLD
// cycles while others wait and gates the muxed data bit with busy.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; gnt/sel/busy are zero, waiting for any req
//   GRANT | sel holds the owner index; hold_cnt counts its grant cycles
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               dout
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  arb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [3:0]         hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               busy_nxt;

  logic [NUM_REQ-1:0] others;
  logic               others_any;
  logic               owner_req;
  logic               hold_at_max;
  logic [SEL_W-1:0]   ptr_rot;
  logic [SEL_W-1:0]   idle_pick;
  logic [SEL_W-1:0]   rot_pick;
  logic               mux_y;

  // sel doubles as the owner index, so gnt and sel can never disagree.
  assign others      = req & ~gnt;
  assign others_any  = |others;
  assign owner_req   = req[sel];
  assign hold_at_max = (hold_cnt >= HOLD_MAX);
  assign ptr_rot     = sel + SEL_W'(1);
  assign idle_pick   = rr_pick(req, ptr);
  assign rot_pick    = rr_pick(others, ptr_rot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = idle_pick;
          gnt_nxt   = idx2onehot(idle_pick);
          busy_nxt  = 1'b1;
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_nxt = ptr_rot;
          if (others_any) begin
            sel_nxt  = rot_pick;
            gnt_nxt  = idx2onehot(rot_pick);
            hold_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            hold_nxt  = '0;
          end
        end else if (hold_at_max && others_any) begin
          ptr_nxt  = ptr_rot;
          sel_nxt  = rot_pick;
          gnt_nxt  = idx2onehot(rot_pick);
          hold_nxt = 4'd1;
        end else if (!hold_at_max) begin
          // A lone owner keeps the grant; the count just parks at HOLD_MAX.
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        hold_nxt  = '0;
      end
    endcase
  end

  mux4_1 u_mux (
    .i0 (din[0]),
    .i1 (din[1]),
    .i2 (din[2]),
    .i3 (din[3]),
    .s1 (sel[1]),
    .s0 (sel[0]),
    .y  (mux_y)
  );

  assign dout = busy & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: per-cycle comparison against a behavioural round-robin model
// plus directed scenarios with literal expectations.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: who owns the mux, the scan start, and how long the owner has held.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_hold  <= 0;
    end else begin : model_step
      bit         nb;
      int         no, np, nh;
      logic [3:0] rest;
      nb = m_busy; no = m_owner; np = m_ptr; nh = m_hold;
      rest = req;
      rest[m_owner] = 1'b0;
      if (!m_busy) begin
        if (req != 4'b0000) begin
          nb = 1'b1; no = first_from(req, m_ptr); nh = 1;
        end
      end else if (!req[m_owner]) begin
        np = (m_owner + 1) % 4;
        if (rest != 4'b0000) begin
          no = first_from(rest, np); nh = 1;
        end else begin
          nb = 1'b0; no = 0; nh = 0;
        end
      end else if (m_hold == MAXH && rest != 4'b0000) begin
        np = (m_owner + 1) % 4;
        no = first_from(rest, np);
        nh = 1;
      end else if (m_hold < MAXH) begin
        nh = m_hold + 1;
      end
      m_busy  <= nb;
      m_owner <= no;
      m_ptr   <= np;
      m_hold  <= nh;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_gnt",  gnt,  m_busy ? (1 << m_owner) : 0);
      check("cyc_sel",  sel,  m_busy ? m_owner : 0);
      check("cyc_busy", busy, m_busy ? 1 : 0);
      check("cyc_dout", dout, m_busy ? int'(din[m_owner]) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] rot_tbl [5];
  int         dout_tbl [4];

  initial begin
    rot_tbl  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dout_tbl = '{0, 1, 0, 1};

    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_gnt",  gnt,  0);
    check("rst_sel",  sel,  0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    tick();
    check("noreq_gnt", gnt, 0);

    // Single requester 2 for three cycles, then release.
    req = 4'b0100; din = 4'b0100;
    tick();
    check("r2_gnt",  gnt,  4'b0100);
    check("r2_sel",  sel,  2);
    check("r2_dout", dout, 1);
    din = 4'b1011;
    #1;
    check("r2_dout_comb", dout, 0);
    tick();
    tick();
    req = 4'b0000;
    tick();
    check("r2_rel_gnt",  gnt,  0);
    check("r2_rel_busy", busy, 0);
    check("r2_rel_ptr",  dut.ptr, 3);

    // All requesting: rotation every MAX_HOLD cycles from ptr=0.
    pulse_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("rot_gnt", gnt, rot_tbl[c / 4]);
    end

    // Asynchronous reset mid-grant clears outputs before the next edge.
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",  gnt,  0);
    check("mid_rst_sel",  sel,  0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dout", dout, 0);
    #1;
    rst_n = 1'b1;
    check("mid_rst_ptr", dut.ptr, 0);

    // Owner 1 drops while 3 and 0 request: handoff to 3 with no bubble.
    req = 4'b0010;
    tick();
    check("h1_gnt", gnt, 4'b0010);
    tick();
    req = 4'b1001;
    tick();
    check("h3_gnt",  gnt,  4'b1000);
    check("h3_busy", busy, 1);
    check("h3_ptr",  dut.ptr, 2);
    req = 4'b0000;
    tick();

    // Lone requester 0 keeps the grant; counter saturates; then requester 1 takes over.
    pulse_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("lone_gnt", gnt, 4'b0001);
    end
    check("lone_hold", dut.hold_cnt, 4);
    req = 4'b0011;
    tick();
    check("lone_rot_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();

    // dout across all four owners with din=1010.
    pulse_reset();
    din = 4'b1010;
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 4 == 0) begin
        check("dsel", sel, c / 4);
        check("dout", dout, dout_tbl[c / 4]);
      end
    end
    req = 4'b0000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters. It registers a one-hot grant and the matching 2-bit select, steers the granted requester's data bit to `dout`, and bounds each ownership to `MAX_HOLD` cycles when others are waiting. It sits directly in front of the existing `mux4_1` select inputs and replaces the free-running select stimulus used today.

## Interface

- `MAX_HOLD`, default 4: maximum consecutive grant cycles while other requests pend; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: request per requester; bit k belongs to requester k.
- `din` input 4: data bit per requester; `din[k]` drives mux input ik.
- `gnt` output 4: registered one-hot grant, or all zero.
- `sel` output 2: registered select {s1,s0}; equals the index of the set `gnt` bit.
- `busy` output 1: registered; 1 whenever `gnt` is non-zero.
- `dout` output 1: `din[sel]` when `busy`=1, else 0; combinational from `din`.

## Operation

- State: `IDLE`, `GRANT`. Also a 2-bit priority pointer `ptr`, a 4-bit `hold_cnt` and a 2-bit owner index.
- Reset values: state `IDLE`, `gnt`=4'b0000, `sel`=2'd0, `busy`=0, `ptr`=0, `hold_cnt`=0, `dout`=0.
- Pick rule: the winner is the first set `req` bit scanning circularly from `ptr`, i.e. ptr, ptr+1, ... mod 4.
- `IDLE`, any `req` set: grant the winner. Go to `GRANT` with `hold_cnt`=1.
- `IDLE`, no `req`: stay in `IDLE`.
- `GRANT`, owner `req` dropped: set `ptr`=owner+1 mod 4.
  - If another `req` is set, grant the pick from the new `ptr` in the same edge. There is no idle bubble, and `hold_cnt` becomes 1.
  - If no other `req` is set, go to `IDLE` and clear `gnt`.
- `GRANT`, owner `req` high, `hold_cnt`==`MAX_HOLD`, another `req` set: rotate. Set `ptr`=owner+1, grant the pick from it, and set `hold_cnt`=1.
- `GRANT`, owner `req` high, otherwise: keep the grant. `hold_cnt` increments and saturates at `MAX_HOLD`. A lone requester therefore keeps its grant indefinitely.
- The rotation decision ignores the owner's own `req` bit when testing for "another `req` set".
- `sel` and `gnt` always update together. An encoding mismatch between them is a design error.

## Timing

- Grant latency: 1 cycle. A `req` sampled high at edge N in `IDLE` gives `gnt`/`sel`/`busy` valid after edge N.
- Release: the owner's `req` sampled low at edge N changes `gnt` after edge N. Handoff to the next requester happens in that same edge.
- Rotation: an owner with competitors holds exactly `MAX_HOLD` cycles, then the grant moves at the next edge.
- `dout` follows `din` of the owner combinationally. Its validity is a same-cycle function of `sel`.
- Reset asserted mid-grant: all outputs return to reset values immediately, without waiting for `clk`. The first grant after `rst_n` rises starts from `ptr`=0.
- Simultaneous requests in `IDLE` resolve by pointer order only. There is no fixed priority.

## Structure

- Package `mux_arb_pkg` holds:
  - `NUM_REQ`=4 and `SEL_W`=2;
  - the state enum `arb_state_t` {`IDLE`, `GRANT`};
  - a `rr_pick` function (request vector, pointer) returning the winner index.
- Sub-module: instantiate the existing `mux4_1` for the datapath. Connect `s1`/`s0` from `sel` and `i0`..`i3` from `din`. Gate its output with `busy` to form `dout`.
- Arbiter FSM, pointer and hold counter live in the top module.

## Test plan

- Reset, then no requests. Required: `gnt`=0000, `sel`=0, `busy`=0, `dout`=0. Assert `rst_n`=0 mid-grant; outputs clear before the next edge.
- `req`=0100 for 3 cycles, then 0000. Required: `gnt`=0100 and `sel`=2 after the first edge; `dout`=`din[2]`; `IDLE` one edge after the drop; `ptr`=3.
- From reset, `req`=1111 held, `MAX_HOLD`=4. Required: grants 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
- Owner 1 holding, `req`=0010 changes to 1001. Required: next edge `gnt`=1000 (ptr=2, next set bit is 3), with no idle cycle.
- Lone requester 0: `req`=0001 held for 20 cycles. Required: `gnt` stays 0001 and `hold_cnt` saturates at 4. Then set `req`=0011; `gnt`=0010 at the next edge.
- `din`=4'b1010 with the grant cycling through all four requesters. Required: `dout` = 0, 1, 0, 1 for `sel`=0, 1, 2, 3.
